// File: rtl/controlador_ascensor_if.sv
// rtl/controlador_ascensor_if.sv - request, lamp, motor and door signals of the elevator controller
interface controlador_ascensor_if;
  logic [9:0] sol_in;
  logic [9:0] sol;
  logic [1:0] piso;
  logic       dir;
  logic       motor_sub;
  logic       motor_baj;
  logic       puerta;
  logic       borrar;
  logic [3:0] cod_borrar;

  // Button side: drives request pulses, observes lamps, motor, door and clear strobe
  modport master (
    output sol_in,
    input  sol, piso, dir, motor_sub, motor_baj, puerta, borrar, cod_borrar
  );

  // Controller side
  modport slave (
    input  sol_in,
    output sol, piso, dir, motor_sub, motor_baj, puerta, borrar, cod_borrar
  );
endinterface

// File: rtl/controlador_ascensor.sv
// rtl/controlador_ascensor.sv - 4-floor SCAN elevator scheduler driving motor, door and request lamps
module controlador_ascensor #(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  controlador_ascensor_if.slave  bus
);

  // One shared down-counter times both floor travel and door dwell
  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    MOVIENDO = 2'd1,
    PUERTA   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    sol_q, sol_d;
  logic [9:0]    mask_q, mask_d;
  logic [1:0]    piso_q, piso_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          motor_sub_q, motor_sub_d;
  logic          motor_baj_q, motor_baj_d;
  logic          puerta_q, puerta_d;
  logic          borrar_q, borrar_d;
  logic [3:0]    cod_q, cod_d;

  // Per-floor views of the pending requests
  logic [3:0] hall_up, hall_dn, cabina, fl_req;

  // Idle-floor evaluation
  logic here_req, here_u, req_ahead, req_behind;

  // Arrival evaluation at the next floor in the travel direction
  logic [1:0] piso_next;
  logic       arr_in_dir, arr_opp, arr_beyond, arr_end, arr_flip, arr_stop, arr_u;

  // Stop bookkeeping shared by the idle and arrival paths
  logic       stop_go, stop_u;
  logic [1:0] stop_f;
  logic [9:0] set_v, clr_v;

  function automatic logic any_above(input logic [3:0] r, input logic [1:0] f);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) > f) a = a | r[i];
    end
    return a;
  endfunction

  function automatic logic any_below(input logic [3:0] r, input logic [1:0] f);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < f) a = a | r[i];
    end
    return a;
  endfunction

  // Cabin bit of the floor plus the single hall bit matching the served direction
  function automatic logic [9:0] clear_mask(input logic [1:0] f, input logic u);
    logic [9:0] m;
    case (f)
      2'd0:    m = 10'h041;
      2'd1:    m = u ? 10'h084 : 10'h082;
      2'd2:    m = u ? 10'h110 : 10'h108;
      default: m = 10'h220;
    endcase
    return m;
  endfunction

  // End floors always report "up" in the served code
  function automatic logic [3:0] stop_code(input logic [1:0] f, input logic u);
    logic uc;
    uc = ((f == 2'd0) || (f == 2'd3)) ? 1'b1 : u;
    return {1'b0, uc, f};
  endfunction

  // Regroup the request vector by floor
  always_comb begin
    hall_up = {1'b0, sol_q[4], sol_q[2], sol_q[0]};
    hall_dn = {sol_q[5], sol_q[3], sol_q[1], 1'b0};
    cabina  = sol_q[9:6];
    fl_req  = hall_up | hall_dn | cabina;
  end

  // Decisions taken while idle: serve this floor, keep direction, or reverse
  always_comb begin
    here_req   = fl_req[piso_q];
    here_u     = (hall_up[piso_q] ^ hall_dn[piso_q]) ? hall_up[piso_q] : dir_q;
    req_ahead  = dir_q ? any_above(fl_req, piso_q) : any_below(fl_req, piso_q);
    req_behind = dir_q ? any_below(fl_req, piso_q) : any_above(fl_req, piso_q);
  end

  // Stop rule on arriving at a floor; a lone opposite hall call with nothing beyond reverses the scan
  always_comb begin
    piso_next  = dir_q ? (piso_q + 2'd1) : (piso_q - 2'd1);
    arr_in_dir = dir_q ? hall_up[piso_next] : hall_dn[piso_next];
    arr_opp    = dir_q ? hall_dn[piso_next] : hall_up[piso_next];
    arr_beyond = dir_q ? any_above(fl_req, piso_next) : any_below(fl_req, piso_next);
    arr_end    = dir_q ? (piso_next == 2'd3) : (piso_next == 2'd0);
    arr_flip   = ~arr_in_dir & arr_opp & ~arr_beyond;
    arr_stop   = cabina[piso_next] | arr_in_dir | arr_flip | arr_end;
    arr_u      = arr_flip ? ~dir_q : dir_q;
  end

  // Next state, timer, request latch and registered output values
  always_comb begin
    state_d     = state_q;
    piso_d      = piso_q;
    dir_d       = dir_q;
    timer_d     = timer_q;
    mask_d      = mask_q;
    motor_sub_d = 1'b0;
    motor_baj_d = 1'b0;
    puerta_d    = 1'b0;
    borrar_d    = 1'b0;
    cod_d       = 4'h0;
    stop_go     = 1'b0;
    stop_f      = piso_q;
    stop_u      = dir_q;
    clr_v       = 10'h000;
    set_v       = bus.sol_in & ~((state_q == PUERTA) ? mask_q : 10'h000);

    case (state_q)
      REPOSO: begin
        if (here_req) begin
          stop_go = 1'b1;
          stop_u  = here_u;
        end else if (req_ahead) begin
          state_d     = MOVIENDO;
          timer_d     = TRAVEL_LOAD;
          motor_sub_d = dir_q;
          motor_baj_d = ~dir_q;
        end else if (req_behind) begin
          state_d     = MOVIENDO;
          dir_d       = ~dir_q;
          timer_d     = TRAVEL_LOAD;
          motor_sub_d = ~dir_q;
          motor_baj_d = dir_q;
        end
      end

      MOVIENDO: begin
        if (timer_q != '0) begin
          timer_d     = timer_q - TW'(1);
          motor_sub_d = dir_q;
          motor_baj_d = ~dir_q;
        end else begin
          piso_d = piso_next;
          if (arr_stop) begin
            stop_go = 1'b1;
            stop_f  = piso_next;
            stop_u  = arr_u;
          end else begin
            timer_d     = TRAVEL_LOAD;
            motor_sub_d = dir_q;
            motor_baj_d = ~dir_q;
          end
        end
      end

      PUERTA: begin
        if (timer_q != '0) begin
          timer_d  = timer_q - TW'(1);
          puerta_d = 1'b1;
        end else begin
          state_d = REPOSO;
          mask_d  = 10'h000;
        end
      end

      default: state_d = REPOSO;
    endcase

    // A stop opens the door, strobes the served code and drops its requests on the same edge
    if (stop_go) begin
      state_d  = PUERTA;
      dir_d    = stop_u;
      timer_d  = DOOR_LOAD;
      puerta_d = 1'b1;
      borrar_d = 1'b1;
      clr_v    = clear_mask(stop_f, stop_u);
      cod_d    = stop_code(stop_f, stop_u);
      mask_d   = clr_v;
    end

    // Clear beats a simultaneous set of the same bit
    sol_d = (sol_q | set_v) & ~clr_v;
  end

  // State and output registers; reset aborts any travel or door cycle and returns to floor 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= REPOSO;
      sol_q       <= 10'h000;
      mask_q      <= 10'h000;
      piso_q      <= 2'd0;
      dir_q       <= 1'b1;
      timer_q     <= '0;
      motor_sub_q <= 1'b0;
      motor_baj_q <= 1'b0;
      puerta_q    <= 1'b0;
      borrar_q    <= 1'b0;
      cod_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      sol_q       <= sol_d;
      mask_q      <= mask_d;
      piso_q      <= piso_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      motor_sub_q <= motor_sub_d;
      motor_baj_q <= motor_baj_d;
      puerta_q    <= puerta_d;
      borrar_q    <= borrar_d;
      cod_q       <= cod_d;
    end
  end

  assign bus.sol        = sol_q;
  assign bus.piso       = piso_q;
  assign bus.dir        = dir_q;
  assign bus.motor_sub  = motor_sub_q;
  assign bus.motor_baj  = motor_baj_q;
  assign bus.puerta     = puerta_q;
  assign bus.borrar     = borrar_q;
  assign bus.cod_borrar = cod_q;

endmodule

// File: tb/tb_controlador_ascensor.sv
// tb/tb_controlador_ascensor.sv - self-checking bench for controlador_ascensor
module tb_controlador_ascensor;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
  localparam logic [20:0] RESET_OUT = {10'h000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

  typedef struct {
    logic [9:0] stim;
    int         ncod;
    logic [3:0] cod0;
    logic [3:0] cod1;
    int         sub_cyc;
    int         baj_cyc;
    int         door_cyc;
    logic [1:0] piso_f;
    logic       dir_f;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  controlador_ascensor_if bus ();

  controlador_ascensor #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int sub_cnt = 0;
  int baj_cnt = 0;
  int door_cnt = 0;
  int safety_viol = 0;
  logic [3:0] exp_q [$];
  logic [3:0] exp_cod;
  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [20:0] out_vec();
    return {bus.sol, bus.piso, bus.dir, bus.motor_sub, bus.motor_baj,
            bus.puerta, bus.borrar, bus.cod_borrar};
  endfunction

  // Scoreboard monitor: pops an expected code on every clear strobe, tallies motor/door cycles
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.motor_sub) sub_cnt++;
        if (bus.motor_baj) baj_cnt++;
        if (bus.puerta)    door_cnt++;
        if ((bus.motor_sub && bus.motor_baj) ||
            (bus.motor_sub && bus.piso == 2'd3) ||
            (bus.motor_baj && bus.piso == 2'd0))
          safety_viol++;
        if (bus.borrar) begin
          if (exp_q.size() == 0) begin
            check("borrar_unexpected", int'(bus.cod_borrar), -1);
          end else begin
            exp_cod = exp_q.pop_front();
            check("cod_borrar", int'(bus.cod_borrar), int'(exp_cod));
          end
        end
      end
    end
  end

  task automatic clear_counts();
    sub_cnt  = 0;
    baj_cnt  = 0;
    door_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset_outputs", int'(out_vec()), int'(RESET_OUT));
    @(negedge clk);
    exp_q.delete();
    clear_counts();
    reset_n = 1'b1;
  endtask

  task automatic pulse(input logic [9:0] bits);
    @(negedge clk);
    bus.sol_in = bits;
    @(negedge clk);
    bus.sol_in = 10'h000;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.sol == 10'h000 && !bus.motor_sub && !bus.motor_baj &&
                 !bus.puerta && !bus.borrar) && n < max_cyc);
    if (n >= max_cyc) check({name, "_idle_timeout"}, n, -1);
  endtask

  initial begin
    tbl[0] = '{10'h100, 1, 4'b0110, 4'b0000,  8, 0, 3, 2'd2, 1'b1};
    tbl[1] = '{10'h202, 2, 4'b0111, 4'b0001, 12, 8, 6, 2'd1, 1'b0};
    tbl[2] = '{10'h001, 1, 4'b0100, 4'b0000,  0, 0, 3, 2'd0, 1'b1};
    tbl[3] = '{10'h020, 1, 4'b0111, 4'b0000, 12, 0, 3, 2'd3, 1'b0};
    tbl[4] = '{10'h008, 1, 4'b0010, 4'b0000,  8, 0, 3, 2'd2, 1'b0};
    tbl[5] = '{10'h240, 2, 4'b0100, 4'b0111, 12, 0, 6, 2'd3, 1'b1};
    tbl[6] = '{10'h018, 2, 4'b0110, 4'b0010,  8, 0, 6, 2'd2, 1'b0};
    tbl[7] = '{10'h006, 2, 4'b0101, 4'b0001,  4, 0, 6, 2'd1, 1'b0};
    tbl[8] = '{10'h090, 2, 4'b0101, 4'b0110,  8, 0, 6, 2'd2, 1'b1};

    bus.sol_in = 10'h000;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table vectors: one request pattern from idle at floor 1, run to idle
    for (int v = 0; v < 9; v++) begin
      do_reset();
      exp_q.push_back(tbl[v].cod0);
      if (tbl[v].ncod > 1) exp_q.push_back(tbl[v].cod1);
      pulse(tbl[v].stim);
      wait_idle($sformatf("v%0d", v), 300);
      check($sformatf("v%0d_piso", v), int'(bus.piso), int'(tbl[v].piso_f));
      check($sformatf("v%0d_dir", v), int'(bus.dir), int'(tbl[v].dir_f));
      check($sformatf("v%0d_motor_sub_cycles", v), sub_cnt, tbl[v].sub_cyc);
      check($sformatf("v%0d_motor_baj_cycles", v), baj_cnt, tbl[v].baj_cyc);
      check($sformatf("v%0d_door_cycles", v), door_cnt, tbl[v].door_cyc);
      check($sformatf("v%0d_codes_left", v), exp_q.size(), 0);
    end

    // Reset in the middle of travel aborts at once and stays parked
    begin
      int n;
      do_reset();
      pulse(10'h200);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.piso != 2'd1 && n < 50);
      check("midrun_reached_f2", int'(bus.piso), 1);
      #2 reset_n = 1'b0;
      #1 check("midrun_reset_outputs", int'(out_vec()), int'(RESET_OUT));
      @(negedge clk);
      exp_q.delete();
      clear_counts();
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midrun_parked_activity", sub_cnt + baj_cnt + door_cnt, 0);
      check("midrun_parked_outputs", int'(out_vec()), int'(RESET_OUT));
    end

    // Latency: sol bit one edge after the pulse, door one edge later
    do_reset();
    exp_q.push_back(4'b0100);
    @(negedge clk);
    bus.sol_in = 10'h001;
    @(posedge clk);
    #1 bus.sol_in = 10'h000;
    check("lat_sol0_set", int'(bus.sol[0]), 1);
    check("lat_door_not_yet", int'(bus.puerta), 0);
    @(posedge clk);
    #1 check("lat_door_open", int'(bus.puerta), 1);
    check("lat_borrar", int'(bus.borrar), 1);
    check("lat_sol0_cleared", int'(bus.sol[0]), 0);
    wait_idle("lat", 100);

    // Door open at F2 up: served bits ignored, the opposite hall call latches
    begin
      int n;
      do_reset();
      exp_q.push_back(4'b0101);
      exp_q.push_back(4'b0001);
      pulse(10'h004);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.puerta && n < 50);
      check("door_f2_opened", int'(bus.puerta), 1);
      bus.sol_in = 10'h086;
      @(posedge clk);
      #1 bus.sol_in = 10'h000;
      check("door_ignore_s2", int'(bus.sol[2]), 0);
      check("door_ignore_s7", int'(bus.sol[7]), 0);
      check("door_latch_s1", int'(bus.sol[1]), 1);
      wait_idle("door", 200);
      check("door_final_piso", int'(bus.piso), 1);
      check("door_final_dir", int'(bus.dir), 0);
      check("door_codes_left", exp_q.size(), 0);
    end

    // Request pulse on the very stop edge: clear wins, no second strobe
    begin
      int n;
      do_reset();
      exp_q.push_back(4'b0110);
      pulse(10'h100);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.motor_sub && n < 20);
      check("race_motor_started", int'(bus.motor_sub), 1);
      repeat (2 * TRAVEL - 1) @(negedge clk);
      bus.sol_in = 10'h100;
      @(posedge clk);
      #1 bus.sol_in = 10'h000;
      check("race_borrar", int'(bus.borrar), 1);
      check("race_sol8_clear", int'(bus.sol[8]), 0);
      check("race_motor_off", int'(bus.motor_sub), 0);
      check("race_piso", int'(bus.piso), 2);
      wait_idle("race", 100);
      repeat (5) @(negedge clk);
      check("race_codes_left", exp_q.size(), 0);
      check("race_sol_final", int'(bus.sol), 0);
    end

    check("motor_safety_violations", safety_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case a sequence wedges the main thread
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d vectors, expected completion", n_vec);
    $fatal(1, "timeout");
  end

endmodule
